// File: rtl/c7bexu_ecl_pkg.sv
// rtl/c7bexu_ecl_pkg.sv - shared encodings and helpers for the c7bexu execute-stage stall control
package c7bexu_ecl_pkg;

    // Exception codes reported to the exception unit
    localparam logic [1:0] EXC_NONE   = 2'b00;
    localparam logic [1:0] EXC_ALE    = 2'b01;
    localparam logic [1:0] EXC_BUSERR = 2'b10;
    localparam logic [1:0] EXC_ECC    = 2'b11;

    // CSR countdown width covers CSR_STALL_CYC up to 15
    localparam int CSR_CNT_W = 4;

    // Derived operating mode, used for debug visibility and assertions
    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_LSU  = 2'd1,
        MODE_CSR  = 2'd2,
        MODE_FULL = 2'd3
    } ecl_mode_e;

    // Width needed to hold an outstanding count of 0..max_out
    function automatic int calc_cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/c7bexu_ecl_lsu_cnt.sv
// rtl/c7bexu_ecl_lsu_cnt.sv - outstanding-LSU up/down counter with clear and sticky underflow
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   inc           one more op outstanding
//   dec           one op completed
//   clr           squash all outstanding ops (highest priority)
//   cnt           registered count
//   cnt_next      next-state count, exposed so the parent can register a stall off it
//   underflow     sticky: dec arrived with nothing outstanding
module c7bexu_ecl_lsu_cnt #(
    parameter int MAX_VAL = 1,
    parameter int W       = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next,
    output logic         underflow
);

    logic underflow_set;

    // A completion with nothing outstanding is an error even if the same
    // cycle also clears the counter.
    assign underflow_set = dec & ~inc & (cnt == '0);

    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && !dec) begin
            // Saturate: the stall normally prevents reaching this, but never wrap
            if (cnt != W'(MAX_VAL)) begin
                cnt_next = cnt + W'(1);
            end
        end else if (dec && !inc) begin
            if (cnt != '0) begin
                cnt_next = cnt - W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            underflow <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (underflow_set) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/c7bexu_ecl_stall_ctl.sv
// rtl/c7bexu_ecl_stall_ctl.sv - execute-stage stall, CSR serialisation and LSU exception reporting
//
// Ports:
//   clk, resetn               clock, asynchronous active-low reset
//   lsu_vld_e, csr_vld_e      ops issued in E (ignored while stall is high)
//   lsu_except_*              LSU exception strobes (ale at ls1, buserr/ecc at ls3)
//   lsu_ecl_data_valid_ls3    load completion
//   lsu_ecl_wr_fin_ls3        store completion
//   flush                     pipeline flush
//   stall                     registered pipeline stall
//   lsu_outstanding           current outstanding LSU count
//   ecl_except_vld/code       one-cycle prioritised exception report
//   err_underflow             sticky completion-with-nothing-outstanding flag
module c7bexu_ecl_stall_ctl
    import c7bexu_ecl_pkg::*;
#(
    parameter int  LSU_MAX_OUT   = 1,
    parameter int  CSR_STALL_CYC = 2,
    localparam int CNT_W         = calc_cnt_w(LSU_MAX_OUT)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             lsu_vld_e,
    input  logic             csr_vld_e,
    input  logic             lsu_except_ale_ls1,
    input  logic             lsu_except_buserr_ls3,
    input  logic             lsu_except_ecc_ls3,
    input  logic             lsu_ecl_data_valid_ls3,
    input  logic             lsu_ecl_wr_fin_ls3,
    input  logic             flush,
    output logic             stall,
    output logic [CNT_W-1:0] lsu_outstanding,
    output logic             ecl_except_vld,
    output logic [1:0]       ecl_except_code,
    output logic             err_underflow
);

    logic                 lsu_acc;
    logic                 csr_acc;
    logic                 exc;
    logic                 done;
    logic [CNT_W-1:0]     cnt_next;
    logic [CSR_CNT_W-1:0] csr_cnt;
    logic [CSR_CNT_W-1:0] csr_cnt_next;
    logic [1:0]           code_next;
    ecl_mode_e            mode;

    assign lsu_acc = lsu_vld_e & ~stall;
    assign csr_acc = csr_vld_e & ~stall;
    assign exc     = lsu_except_ale_ls1 | lsu_except_buserr_ls3 | lsu_except_ecc_ls3;
    assign done    = lsu_ecl_data_valid_ls3 | lsu_ecl_wr_fin_ls3 | exc;

    // Any exception squashes every younger op in the LSU, so the count drops to zero.
    c7bexu_ecl_lsu_cnt #(
        .MAX_VAL (LSU_MAX_OUT),
        .W       (CNT_W)
    ) u_lsu_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .inc       (lsu_acc),
        .dec       (done),
        .clr       (flush | exc),
        .cnt       (lsu_outstanding),
        .cnt_next  (cnt_next),
        .underflow (err_underflow)
    );

    always_comb begin
        csr_cnt_next = csr_cnt;
        if (flush) begin
            csr_cnt_next = '0;
        end else if (csr_acc) begin
            csr_cnt_next = CSR_CNT_W'(CSR_STALL_CYC);
        end else if (csr_cnt != '0) begin
            csr_cnt_next = csr_cnt - CSR_CNT_W'(1);
        end
    end

    // ls3 ops are older than the ls1 op, so bus/ECC errors win over ALE.
    always_comb begin
        code_next = EXC_NONE;
        if (lsu_except_buserr_ls3) begin
            code_next = EXC_BUSERR;
        end else if (lsu_except_ecc_ls3) begin
            code_next = EXC_ECC;
        end else if (lsu_except_ale_ls1) begin
            code_next = EXC_ALE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csr_cnt         <= '0;
            stall           <= 1'b0;
            ecl_except_vld  <= 1'b0;
            ecl_except_code <= EXC_NONE;
        end else begin
            csr_cnt         <= csr_cnt_next;
            stall           <= (cnt_next >= CNT_W'(LSU_MAX_OUT)) | (csr_cnt_next != '0);
            ecl_except_vld  <= exc;
            ecl_except_code <= code_next;
        end
    end

    always_comb begin
        if (lsu_outstanding == CNT_W'(LSU_MAX_OUT)) begin
            mode = MODE_FULL;
        end else if (lsu_outstanding != '0) begin
            mode = MODE_LSU;
        end else if (csr_cnt != '0) begin
            mode = MODE_CSR;
        end else begin
            mode = MODE_IDLE;
        end
    end

    // Stall must be high whenever the outstanding window is full or a CSR is serialising.
    assert property (@(posedge clk) disable iff (!resetn)
        ((mode == MODE_FULL) || (mode == MODE_CSR)) |-> stall);

endmodule

// File: tb/tb_c7bexu_ecl_stall_ctl.sv
// tb/tb_c7bexu_ecl_stall_ctl.sv - directed self-checking bench for c7bexu_ecl_stall_ctl
module tb_c7bexu_ecl_stall_ctl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic lsu_vld_e = 1'b0, csr_vld_e = 1'b0, flush = 1'b0;
    logic ale = 1'b0, buserr = 1'b0, ecc = 1'b0, dvalid = 1'b0, wrfin = 1'b0;

    logic       stall_1, exv_1, unf_1;
    logic [0:0] cnt_1;
    logic [1:0] code_1;
    logic       stall_2, exv_2, unf_2;
    logic [1:0] cnt_2, code_2;
    logic       stall_3, exv_3, unf_3;
    logic [1:0] cnt_3, code_3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    c7bexu_ecl_stall_ctl u_dut (
        .clk(clk), .resetn(resetn), .lsu_vld_e(lsu_vld_e), .csr_vld_e(csr_vld_e),
        .lsu_except_ale_ls1(ale), .lsu_except_buserr_ls3(buserr), .lsu_except_ecc_ls3(ecc),
        .lsu_ecl_data_valid_ls3(dvalid), .lsu_ecl_wr_fin_ls3(wrfin), .flush(flush),
        .stall(stall_1), .lsu_outstanding(cnt_1), .ecl_except_vld(exv_1),
        .ecl_except_code(code_1), .err_underflow(unf_1)
    );

    c7bexu_ecl_stall_ctl #(.LSU_MAX_OUT(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .lsu_vld_e(lsu_vld_e), .csr_vld_e(csr_vld_e),
        .lsu_except_ale_ls1(ale), .lsu_except_buserr_ls3(buserr), .lsu_except_ecc_ls3(ecc),
        .lsu_ecl_data_valid_ls3(dvalid), .lsu_ecl_wr_fin_ls3(wrfin), .flush(flush),
        .stall(stall_2), .lsu_outstanding(cnt_2), .ecl_except_vld(exv_2),
        .ecl_except_code(code_2), .err_underflow(unf_2)
    );

    c7bexu_ecl_stall_ctl #(.LSU_MAX_OUT(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .lsu_vld_e(lsu_vld_e), .csr_vld_e(csr_vld_e),
        .lsu_except_ale_ls1(ale), .lsu_except_buserr_ls3(buserr), .lsu_except_ecc_ls3(ecc),
        .lsu_ecl_data_valid_ls3(dvalid), .lsu_ecl_wr_fin_ls3(wrfin), .flush(flush),
        .stall(stall_3), .lsu_outstanding(cnt_3), .ecl_except_vld(exv_3),
        .ecl_except_code(code_3), .err_underflow(unf_3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lsu_vld_e = 1'b0; csr_vld_e = 1'b0; flush = 1'b0;
        ale = 1'b0; buserr = 1'b0; ecc = 1'b0; dvalid = 1'b0; wrfin = 1'b0;
    endtask

    task automatic reset_all();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tests++; if (stall_1 !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall_1); end
        tests++; if (cnt_1 !== 1'b0) begin fails++; $display("FAIL reset_cnt got %0d want 0", cnt_1); end
        tests++; if (exv_1 !== 1'b0 || code_1 !== 2'b00) begin fails++; $display("FAIL reset_exc got %b/%b want 0/00", exv_1, code_1); end
        tests++; if (unf_1 !== 1'b0) begin fails++; $display("FAIL reset_unf got %b want 0", unf_1); end
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (stall_1 !== 1'b0 || cnt_1 !== 1'b0 || exv_1 !== 1'b0) begin
                fails++;
                $display("FAIL idle_%0d got stall=%b cnt=%0d exv=%b want 0/0/0", i, stall_1, cnt_1, exv_1);
            end
        end
    endtask

    task automatic test_csr();
        logic [3:0] want;
        reset_all();
        want = 4'b0011;
        csr_vld_e = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) csr_vld_e = 1'b0;
            tick();
            tests++;
            if (stall_1 !== want[i]) begin
                fails++;
                $display("FAIL csr_stall_cyc%0d got %b want %b", i, stall_1, want[i]);
            end
        end
    endtask

    task automatic test_lsu_max2();
        reset_all();
        lsu_vld_e = 1'b1;
        tick();
        tests++; if (cnt_2 !== 2'd1 || stall_2 !== 1'b0) begin fails++; $display("FAIL max2_first got cnt=%0d stall=%b want 1/0", cnt_2, stall_2); end
        tick();
        tests++; if (cnt_2 !== 2'd2 || stall_2 !== 1'b1) begin fails++; $display("FAIL max2_second got cnt=%0d stall=%b want 2/1", cnt_2, stall_2); end
        lsu_vld_e = 1'b0; dvalid = 1'b1;
        tick();
        tests++; if (cnt_2 !== 2'd1 || stall_2 !== 1'b0) begin fails++; $display("FAIL max2_dvalid got cnt=%0d stall=%b want 1/0", cnt_2, stall_2); end
        dvalid = 1'b0; wrfin = 1'b1;
        tick();
        tests++; if (cnt_2 !== 2'd0 || unf_2 !== 1'b0) begin fails++; $display("FAIL max2_wrfin got cnt=%0d unf=%b want 0/0", cnt_2, unf_2); end
        wrfin = 1'b0;
    endtask

    task automatic test_ale();
        reset_all();
        lsu_vld_e = 1'b1;
        tick();
        tests++; if (cnt_1 !== 1'b1 || stall_1 !== 1'b1) begin fails++; $display("FAIL ale_issue got cnt=%0d stall=%b want 1/1", cnt_1, stall_1); end
        lsu_vld_e = 1'b0; ale = 1'b1;
        tick();
        tests++; if (stall_1 !== 1'b0 || cnt_1 !== 1'b0) begin fails++; $display("FAIL ale_cnt got cnt=%0d stall=%b want 0/0", cnt_1, stall_1); end
        tests++; if (exv_1 !== 1'b1 || code_1 !== 2'b01) begin fails++; $display("FAIL ale_report got vld=%b code=%b want 1/01", exv_1, code_1); end
        ale = 1'b0;
        tick();
        tests++; if (exv_1 !== 1'b0) begin fails++; $display("FAIL ale_pulse got vld=%b want 0", exv_1); end
    endtask

    task automatic test_exc_priority();
        reset_all();
        lsu_vld_e = 1'b1;
        tick();
        tick();
        tests++; if (cnt_3 !== 2'd2 || stall_3 !== 1'b0) begin fails++; $display("FAIL max3_setup got cnt=%0d stall=%b want 2/0", cnt_3, stall_3); end
        lsu_vld_e = 1'b0; buserr = 1'b1; ale = 1'b1;
        tick();
        tests++; if (exv_3 !== 1'b1 || code_3 !== 2'b10) begin fails++; $display("FAIL buserr_ale_code got vld=%b code=%b want 1/10", exv_3, code_3); end
        tests++; if (cnt_3 !== 2'd0 || stall_3 !== 1'b0) begin fails++; $display("FAIL buserr_ale_cnt got cnt=%0d stall=%b want 0/0", cnt_3, stall_3); end
        clear_inputs();
        reset_all();
        lsu_vld_e = 1'b1;
        tick();
        lsu_vld_e = 1'b0; ecc = 1'b1; ale = 1'b1; flush = 1'b1;
        tick();
        tests++; if (exv_1 !== 1'b1 || code_1 !== 2'b11) begin fails++; $display("FAIL ecc_ale_flush got vld=%b code=%b want 1/11", exv_1, code_1); end
        clear_inputs();
    endtask

    task automatic test_underflow();
        reset_all();
        dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        tests++; if (unf_1 !== 1'b1 || cnt_1 !== 1'b0) begin fails++; $display("FAIL underflow_set got unf=%b cnt=%0d want 1/0", unf_1, cnt_1); end
        lsu_vld_e = 1'b1;
        tick();
        lsu_vld_e = 1'b0; wrfin = 1'b1;
        tick();
        wrfin = 1'b0;
        tick();
        tests++; if (unf_1 !== 1'b1 || cnt_1 !== 1'b0) begin fails++; $display("FAIL underflow_sticky got unf=%b cnt=%0d want 1/0", unf_1, cnt_1); end
    endtask

    task automatic test_flush_csr();
        reset_all();
        csr_vld_e = 1'b1;
        tick();
        csr_vld_e = 1'b0;
        tests++; if (stall_1 !== 1'b1) begin fails++; $display("FAIL flush_pre got stall=%b want 1", stall_1); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++; if (stall_1 !== 1'b0) begin fails++; $display("FAIL flush_csr got stall=%b want 0", stall_1); end
    endtask

    task automatic test_async_reset();
        reset_all();
        lsu_vld_e = 1'b1; csr_vld_e = 1'b1;
        tick();
        lsu_vld_e = 1'b0; csr_vld_e = 1'b0; buserr = 1'b1;
        tests++; if (stall_1 !== 1'b1 || cnt_1 !== 1'b1) begin fails++; $display("FAIL both_acc got stall=%b cnt=%0d want 1/1", stall_1, cnt_1); end
        buserr = 1'b0;
        tick();
        tests++; if (stall_2 !== 1'b1) begin fails++; $display("FAIL async_pre got stall=%b want 1", stall_2); end
        #2;
        resetn = 1'b0;
        #1;
        tests++; if (stall_1 !== 1'b0 || cnt_1 !== 1'b0 || exv_1 !== 1'b0) begin fails++; $display("FAIL async_rst1 got stall=%b cnt=%0d exv=%b want 0/0/0", stall_1, cnt_1, exv_1); end
        tests++; if (stall_2 !== 1'b0 || cnt_2 !== 2'd0 || code_2 !== 2'b00) begin fails++; $display("FAIL async_rst2 got stall=%b cnt=%0d code=%b want 0/0/00", stall_2, cnt_2, code_2); end
        lsu_vld_e = 1'b1; csr_vld_e = 1'b1; dvalid = 1'b1;
        tick();
        tests++; if (stall_1 !== 1'b0 || cnt_1 !== 1'b0 || unf_1 !== 1'b0) begin fails++; $display("FAIL rst_hold got stall=%b cnt=%0d unf=%b want 0/0/0", stall_1, cnt_1, unf_1); end
        clear_inputs();
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_csr();
        test_lsu_max2();
        test_ale();
        test_exc_priority();
        test_underflow();
        test_flush_csr();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
